// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS:cc stopwatch sequencer with a centisecond prescaler, cascaded
// csec/sec/min counters and a lap freeze. Optional STOP-state blink under `STOPWATCH_BLINK_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_ss,
    input  logic       i_btn_lap,
    input  logic       i_btn_clr,
    output logic [5:0] o_disp_min,
    output logic [5:0] o_disp_sec,
    output logic [6:0] o_disp_csec,
    output logic [5:0] o_dp,
    output logic       o_running,
    output logic       o_lap,
    output logic       o_wrap,
    output logic       o_blank
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ZERO = {PW{1'b0}};
    localparam logic [5:0]      DP_PATTERN = 6'b010100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BTN_NONE = 2'd0,
        BTN_LAP  = 2'd1,
        BTN_SS   = 2'd2,
        BTN_CLR  = 2'd3
    } btn_t;

    state_t        state_q, state_d;
    btn_t          btn_s;
    logic          counting_s, tick_s, clear_s, restart_s, lap_take_s;

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    csec_q, csec_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic          wrap_q, wrap_d;

    logic [6:0]    lap_csec_q, lap_csec_d;
    logic [5:0]    lap_sec_q, lap_sec_d;
    logic [5:0]    lap_min_q, lap_min_d;

    logic [6:0]    disp_csec_q, disp_csec_d;
    logic [5:0]    disp_sec_q, disp_sec_d;
    logic [5:0]    disp_min_q, disp_min_d;
    logic [5:0]    dp_q;
    logic          running_q, running_d;
    logic          lap_flag_q, lap_flag_d;

    // Only the highest-priority pulse is acted on; the rest are dropped.
    always_comb begin
        btn_s = BTN_NONE;
        if (i_btn_clr) begin
            btn_s = BTN_CLR;
        end else if (i_btn_ss) begin
            btn_s = BTN_SS;
        end else if (i_btn_lap) begin
            btn_s = BTN_LAP;
        end else begin
            btn_s = BTN_NONE;
        end
    end

    assign counting_s = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick_s     = counting_s && (presc_q == PRESC_MAX);

    // Next-state logic and the one-cycle action strobes it raises.
    always_comb begin
        state_d    = state_q;
        clear_s    = 1'b0;
        restart_s  = 1'b0;
        lap_take_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s == BTN_SS) begin
                    state_d   = ST_RUN;
                    restart_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_LAP: begin
                if (btn_s == BTN_SS) begin
                    state_d = ST_STOP;
                end else if (btn_s == BTN_LAP) begin
                    state_d    = ST_LAP;
                    lap_take_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_STOP: begin
                if (btn_s == BTN_CLR) begin
                    state_d = ST_IDLE;
                    clear_s = 1'b1;
                end else if (btn_s == BTN_SS) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler and cascaded counter chain; a tick on a stopping edge still counts.
    always_comb begin
        presc_d = presc_q;
        csec_d  = csec_q;
        sec_d   = sec_q;
        min_d   = min_q;
        wrap_d  = wrap_q;
        if (clear_s) begin
            presc_d = PRESC_ZERO;
            csec_d  = 7'd0;
            sec_d   = 6'd0;
            min_d   = 6'd0;
            wrap_d  = 1'b0;
        end else if (restart_s) begin
            presc_d = PRESC_ZERO;
        end else if (tick_s) begin
            presc_d = PRESC_ZERO;
            if (csec_q == 7'd99) begin
                csec_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        wrap_d = 1'b1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                csec_d = csec_q + 7'd1;
            end
        end else if (counting_s) begin
            presc_d = presc_q + 1'b1;
        end else begin
            presc_d = presc_q;
        end
    end

    // Lap copy captures the live value as it stood before this edge's tick.
    always_comb begin
        lap_csec_d = lap_csec_q;
        lap_sec_d  = lap_sec_q;
        lap_min_d  = lap_min_q;
        if (clear_s) begin
            lap_csec_d = 7'd0;
            lap_sec_d  = 6'd0;
            lap_min_d  = 6'd0;
        end else if (lap_take_s) begin
            lap_csec_d = csec_q;
            lap_sec_d  = sec_q;
            lap_min_d  = min_q;
        end else begin
            lap_csec_d = lap_csec_q;
        end
    end

    // Output registers are loaded from next-state values so they track the state after each edge.
    always_comb begin
        disp_csec_d = csec_d;
        disp_sec_d  = sec_d;
        disp_min_d  = min_d;
        running_d   = (state_d == ST_RUN) || (state_d == ST_LAP);
        lap_flag_d  = (state_d == ST_LAP);
        if (state_d == ST_LAP) begin
            disp_csec_d = lap_csec_d;
            disp_sec_d  = lap_sec_d;
            disp_min_d  = lap_min_d;
        end else begin
            disp_csec_d = csec_d;
        end
    end

    // State, counter, lap copy and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= PRESC_ZERO;
            csec_q      <= 7'd0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            wrap_q      <= 1'b0;
            lap_csec_q  <= 7'd0;
            lap_sec_q   <= 6'd0;
            lap_min_q   <= 6'd0;
            disp_csec_q <= 7'd0;
            disp_sec_q  <= 6'd0;
            disp_min_q  <= 6'd0;
            dp_q        <= DP_PATTERN;
            running_q   <= 1'b0;
            lap_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            csec_q      <= csec_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            wrap_q      <= wrap_d;
            lap_csec_q  <= lap_csec_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            disp_csec_q <= disp_csec_d;
            disp_sec_q  <= disp_sec_d;
            disp_min_q  <= disp_min_d;
            dp_q        <= DP_PATTERN;
            running_q   <= running_d;
            lap_flag_q  <= lap_flag_d;
        end
    end

`ifdef STOPWATCH_BLINK_EN
    localparam logic [5:0] BLINK_LAST = 6'd49;

    logic [PW-1:0] blink_div_q, blink_div_d;
    logic [5:0]    blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;

    // Separate blink timebase so the held count prescaler is untouched while stopped.
    always_comb begin
        blink_div_d = blink_div_q;
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if ((state_q != ST_STOP) || (state_d != ST_STOP)) begin
            blink_div_d = PRESC_ZERO;
            blink_cnt_d = 6'd0;
            blank_d     = 1'b0;
        end else if (blink_div_q == PRESC_MAX) begin
            blink_div_d = PRESC_ZERO;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 6'd0;
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 6'd1;
            end
        end else begin
            blink_div_d = blink_div_q + 1'b1;
        end
    end

    // Blink timebase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_div_q <= PRESC_ZERO;
            blink_cnt_q <= 6'd0;
            blank_q     <= 1'b0;
        end else begin
            blink_div_q <= blink_div_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign o_blank = blank_q;
`else
    assign o_blank = 1'b0;
`endif

    assign o_disp_min  = disp_min_q;
    assign o_disp_sec  = disp_sec_q;
    assign o_disp_csec = disp_csec_q;
    assign o_dp        = dp_q;
    assign o_running   = running_q;
    assign o_lap       = lap_flag_q;
    assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a total-centisecond model checked every cycle, plus
// hand-computed literal expectations for each directed scenario (TICK_DIV = 4).
module tb_stopwatch_ctrl;

    localparam int TD      = 4;
    localparam int FULL_CS = 360000;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STOP  = 2;
    localparam int M_LAP   = 3;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       btn_ss  = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic       preload = 1'b0;
    logic [5:0] disp_min, disp_sec, dp;
    logic [6:0] disp_csec;
    logic       running, lapo, wrap, blank;

    int   m_mode, m_live, m_lapc, m_phase, m_stopn;
    logic m_wrap;
    int   n_checks = 0;
    int   n_pass   = 0;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst),
        .i_btn_ss(btn_ss), .i_btn_lap(btn_lap), .i_btn_clr(btn_clr),
        .o_disp_min(disp_min), .o_disp_sec(disp_sec), .o_disp_csec(disp_csec),
        .o_dp(dp), .o_running(running), .o_lap(lapo), .o_wrap(wrap), .o_blank(blank)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed time as a single centisecond count.
    always @(posedge clk or posedge rst) begin : model
        int   nl, np, nm, nlap, btn;
        logic nw;
        if (rst) begin
            m_mode  <= M_IDLE;
            m_live  <= 0;
            m_lapc  <= 0;
            m_phase <= 0;
            m_wrap  <= 1'b0;
            m_stopn <= 0;
        end else begin
            nl   = m_live;
            np   = m_phase;
            nm   = m_mode;
            nlap = m_lapc;
            nw   = m_wrap;
            btn  = btn_clr ? 3 : (btn_ss ? 2 : (btn_lap ? 1 : 0));
            if (m_mode == M_RUN || m_mode == M_LAP) begin
                if (m_phase == TD - 1) begin
                    nl = (m_live + 1) % FULL_CS;
                    if (nl == 0) nw = 1'b1;
                end
                np = (m_phase + 1) % TD;
            end
            if (preload) nl = FULL_CS - 1;
            if (m_mode == M_IDLE && btn == 2) begin
                nm = M_RUN;
                np = 0;
            end else if ((m_mode == M_RUN || m_mode == M_LAP) && btn == 2) begin
                nm = M_STOP;
            end else if ((m_mode == M_RUN || m_mode == M_LAP) && btn == 1) begin
                nm   = M_LAP;
                nlap = m_live;
            end else if (m_mode == M_STOP && btn == 3) begin
                nm = M_IDLE; nl = 0; np = 0; nlap = 0; nw = 1'b0;
            end else if (m_mode == M_STOP && btn == 2) begin
                nm = M_RUN;
            end
            m_stopn <= (m_mode == M_STOP && nm == M_STOP) ? m_stopn + 1 : 0;
            m_mode  <= nm;
            m_live  <= nl;
            m_lapc  <= nlap;
            m_phase <= np;
            m_wrap  <= nw;
        end
    end

    task automatic cmp_cycle();
        int         ecs;
        logic [5:0] emin, esec;
        logic [6:0] ecsec;
        logic       erun, elap, eblank;
        ecs    = (m_mode == M_LAP) ? m_lapc : m_live;
        emin   = 6'(ecs / 6000);
        esec   = 6'((ecs / 100) % 60);
        ecsec  = 7'(ecs % 100);
        erun   = (m_mode == M_RUN || m_mode == M_LAP);
        elap   = (m_mode == M_LAP);
`ifdef STOPWATCH_BLINK_EN
        eblank = (m_mode == M_STOP) && (((m_stopn / (50 * TD)) % 2) == 1);
`else
        eblank = 1'b0;
`endif
        n_checks++;
        if (disp_min === emin && disp_sec === esec && disp_csec === ecsec &&
            dp === 6'b010100 && running === erun && lapo === elap &&
            wrap === m_wrap && blank === eblank) begin
            n_pass++;
        end else begin
            $display("FAIL cycle t=%0t: got %0d:%0d.%0d dp=%b run=%b lap=%b wrap=%b blank=%b, expected %0d:%0d.%0d dp=010100 run=%b lap=%b wrap=%b blank=%b",
                     $time, disp_min, disp_sec, disp_csec, dp, running, lapo, wrap, blank,
                     emin, esec, ecsec, erun, elap, m_wrap, eblank);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cmp_cycle();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        btn_ss  = s;
        btn_lap = l;
        btn_clr = c;
        step();
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic chk_disp(input string name, input int mm, input int ss, input int cc);
        n_checks++;
        if (disp_min == 6'(mm) && disp_sec == 6'(ss) && disp_csec == 7'(cc)) n_pass++;
        else $display("FAIL %s: got %0d:%0d.%0d, expected %0d:%0d.%0d",
                      name, disp_min, disp_sec, disp_csec, mm, ss, cc);
    endtask

    initial begin
        int blink_hi;
`ifdef STOPWATCH_BLINK_EN
        blink_hi = 1;
`else
        blink_hi = 0;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        chk_disp("reset_disp", 0, 0, 0);
        chk("reset_dp", int'(dp), 20);
        chk("reset_running", int'(running), 0);

        // Count, stop, resume from the held prescaler phase.
        press(1'b1, 1'b0, 1'b0);
        run(400);
        chk_disp("run_400clk", 0, 1, 0);
        chk("run_running", int'(running), 1);
        press(1'b1, 1'b0, 1'b0);
        chk_disp("stop_hold", 0, 1, 0);
        chk("stop_running", int'(running), 0);
        run(8);
        chk_disp("stop_frozen", 0, 1, 0);
        press(1'b1, 1'b0, 1'b0);
        run(4);
        chk_disp("resume_partial", 0, 1, 1);

        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk_disp("clr_idle", 0, 0, 0);

        // Lap freeze while the live count keeps going.
        press(1'b1, 1'b0, 1'b0);
        run(200);
        chk_disp("run_half", 0, 0, 50);
        press(1'b0, 1'b1, 1'b0);
        chk_disp("lap_frozen", 0, 0, 50);
        chk("lap_flag", int'(lapo), 1);
        run(200);
        chk_disp("lap_still", 0, 0, 50);
        chk("lap_running", int'(running), 1);
        press(1'b1, 1'b0, 1'b0);
        chk_disp("lap_exit_live", 0, 1, 0);
        chk("lap_exit_flag", int'(lapo), 0);

        // Re-lap on a tick edge captures the pre-increment value.
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        run(8);
        press(1'b0, 1'b1, 1'b0);
        chk_disp("relap_on_tick", 0, 1, 2);
        press(1'b1, 1'b0, 1'b0);
        chk_disp("relap_stop_live", 0, 1, 3);

        // Simultaneous pulses.
        press(1'b1, 1'b0, 1'b1);
        chk_disp("ss_clr_stop", 0, 0, 0);
        chk("ss_clr_running", int'(running), 0);
        press(1'b1, 1'b0, 1'b0);
        run(10);
        press(1'b1, 1'b1, 1'b0);
        chk_disp("ss_lap_run", 0, 0, 2);
        chk("ss_lap_flag", int'(lapo), 0);
        chk("ss_lap_running", int'(running), 0);

        // Full-scale rollover and sticky wrap.
        press(1'b0, 1'b0, 1'b1);
        force dut.csec_q = 7'd99;
        force dut.sec_q  = 6'd59;
        force dut.min_q  = 6'd59;
        preload = 1'b1;
        step();
        preload = 1'b0;
        release dut.csec_q;
        release dut.sec_q;
        release dut.min_q;
        chk_disp("preload", 59, 59, 99);
        press(1'b1, 1'b0, 1'b0);
        run(3);
        chk_disp("pre_wrap", 59, 59, 99);
        chk("pre_wrap_flag", int'(wrap), 0);
        step();
        chk_disp("wrapped", 0, 0, 0);
        chk("wrap_set", int'(wrap), 1);
        run(4);
        chk_disp("post_wrap", 0, 0, 1);
        press(1'b1, 1'b0, 1'b0);
        chk("wrap_sticky", int'(wrap), 1);
        press(1'b0, 1'b0, 1'b1);
        chk("wrap_cleared", int'(wrap), 0);

        // Blank request across a long STOP.
        press(1'b1, 1'b0, 1'b0);
        run(20);
        press(1'b1, 1'b0, 1'b0);
        run(199);
        chk("blank_199", int'(blank), 0);
        step();
        chk("blank_200", int'(blank), blink_hi);
        run(199);
        step();
        chk("blank_400", int'(blank), 0);
        chk_disp("blink_frozen", 0, 0, 5);

        // Asynchronous reset in the middle of a count.
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        run(492);
        chk_disp("pre_reset", 0, 1, 23);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_disp("reset_mid", 0, 0, 0);
        chk("reset_mid_running", int'(running), 0);
        chk("reset_mid_dp", int'(dp), 20);
        run(8);
        chk_disp("reset_idle", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
